// File: rtl/air_ctrl.sv
// Air-conditioner controller: mode FSM, demand register and equipment FSM with compressor lockout.
// Latency: button/temperature -> demand 1 cycle, demand -> equipment enable 1 cycle; outputs registered.
// Backpressure: none; button pulses are consumed the cycle they arrive, lockout holds off restarts.
module air_ctrl #(
  parameter int         TICK_DIV  = 50_000_000,
  parameter logic [7:0] MIN_OFF_S = 8'd5,
  parameter logic [7:0] HYST      = 8'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rise_button,
  input  logic [7:0] tem_reg,
  input  logic [7:0] set_tem,
  output logic [1:0] air_state,
  output logic       cool_on,
  output logic       heat_on,
  output logic       fan_on,
  output logic       lockout
);

  localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PMAX    = PW'(TICK_DIV - 1);
  localparam logic [7:0]     FAN_MIN = MIN_OFF_S >> 1;

  typedef enum logic [1:0] {M_MANUAL = 2'b00, M_AUTO = 2'b01, M_STOP = 2'b10, M_SET = 2'b11} mode_t;
  typedef enum logic [1:0] {D_NONE = 2'b00, D_COOL = 2'b01, D_HEAT = 2'b10} dem_t;
  typedef enum logic [1:0] {E_IDLE = 2'b00, E_COOL = 2'b01, E_HEAT = 2'b10, E_LOCK = 2'b11} eq_t;

  mode_t         mode_q, mode_d;
  dem_t          dem_q, dem_d;
  eq_t           eq_q, eq_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          cool_q, cool_d, heat_q, heat_d, fan_q, fan_d, lock_q, lock_d;
  logic          tick;
  logic          b_mode, b_set, b_exit, b_up, b_dn;
  logic [8:0]    tem9, set9, hyst9;
  logic          want_cool, want_heat;

  // Only the highest-priority pressed button is acted on: mode > set > exit > up > down.
  always_comb begin
    b_mode = rise_button[2];
    b_set  = rise_button[1] & ~rise_button[2];
    b_exit = rise_button[3] & ~rise_button[2] & ~rise_button[1];
    b_up   = rise_button[0] & ~rise_button[3] & ~rise_button[2] & ~rise_button[1];
    b_dn   = rise_button[4] & ~rise_button[3] & ~rise_button[2] & ~rise_button[1] & ~rise_button[0];
  end

  // Nine-bit compares so that 255 + HYST cannot wrap around.
  always_comb begin
    tem9      = {1'b0, tem_reg};
    set9      = {1'b0, set_tem};
    hyst9     = {1'b0, HYST};
    want_cool = tem9 > (set9 + hyst9);
    want_heat = (tem9 + hyst9) < set9;
  end

  // One-second prescaler; tick marks the cycle in which the count wraps.
  always_comb begin
    tick    = (presc_q == PMAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Mode FSM next state.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      M_MANUAL: if (b_mode) mode_d = M_AUTO;
      M_AUTO: begin
        if (b_mode)     mode_d = M_STOP;
        else if (b_set) mode_d = M_SET;
      end
      M_STOP:   if (b_mode) mode_d = M_MANUAL;
      M_SET: begin
        if (b_mode)      mode_d = M_STOP;
        else if (b_exit) mode_d = M_AUTO;
      end
    endcase
  end

  // Demand register: buttons in MANUAL, thermostat with hysteresis in AUTO, frozen in SET_TEM.
  always_comb begin
    dem_d = dem_q;
    case (mode_q)
      M_MANUAL: begin
        if (b_up)        dem_d = D_COOL;
        else if (b_dn)   dem_d = D_HEAT;
        else if (b_exit) dem_d = D_NONE;
      end
      M_AUTO: begin
        if (want_cool)                               dem_d = D_COOL;
        else if (want_heat)                          dem_d = D_HEAT;
        else if (dem_q == D_COOL && tem9 <= set9)    dem_d = D_NONE;
        else if (dem_q == D_HEAT && tem9 >= set9)    dem_d = D_NONE;
      end
      M_STOP:   dem_d = D_NONE;
      M_SET:    dem_d = dem_q;
    endcase
  end

  // Equipment FSM: any change away from a running state passes through a timed lockout.
  always_comb begin
    eq_d  = eq_q;
    cnt_d = cnt_q;
    case (eq_q)
      E_IDLE: begin
        if (dem_q == D_COOL)      eq_d = E_COOL;
        else if (dem_q == D_HEAT) eq_d = E_HEAT;
      end
      E_COOL: if (dem_q != D_COOL) begin eq_d = E_LOCK; cnt_d = MIN_OFF_S; end
      E_HEAT: if (dem_q != D_HEAT) begin eq_d = E_LOCK; cnt_d = MIN_OFF_S; end
      E_LOCK: begin
        if (cnt_q == 8'd0) eq_d = E_IDLE;
        else if (tick)     cnt_d = cnt_q - 8'd1;
      end
    endcase
    cool_d = (eq_d == E_COOL);
    heat_d = (eq_d == E_HEAT);
    lock_d = (eq_d == E_LOCK);
    fan_d  = cool_d | heat_d | (lock_d & (cnt_d > FAN_MIN));
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= M_MANUAL;
      dem_q   <= D_NONE;
      eq_q    <= E_IDLE;
      presc_q <= '0;
      cnt_q   <= 8'd0;
      cool_q  <= 1'b0;
      heat_q  <= 1'b0;
      fan_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dem_q   <= dem_d;
      eq_q    <= eq_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      cool_q  <= cool_d;
      heat_q  <= heat_d;
      fan_q   <= fan_d;
      lock_q  <= lock_d;
    end
  end

  assign air_state = mode_q;
  assign cool_on   = cool_q;
  assign heat_on   = heat_q;
  assign fan_on    = fan_q;
  assign lockout   = lock_q;

endmodule
